// File: rtl/universal_shift_register_n_if.sv
// universal_shift_register_n_if: control, data and status bundle for the universal shift register
interface universal_shift_register_n_if #(parameter int WIDTH = 8, parameter int CNT_W = 3);
  logic enable;
  logic [2:0] mode;
  logic start;
  logic [CNT_W-1:0] shamt;
  logic [WIDTH-1:0] data_load;
  logic serial_in_l;
  logic serial_in_r;
  logic [WIDTH-1:0] out_final;
  logic shift_out;
  logic busy;
  logic done;
  modport master (
    output enable, mode, start, shamt, data_load, serial_in_l, serial_in_r,
    input out_final, shift_out, busy, done
  );
  modport slave (
    input enable, mode, start, shamt, data_load, serial_in_l, serial_in_r,
    output out_final, shift_out, busy, done
  );
endinterface

// File: rtl/universal_shift_register_n.sv
// universal_shift_register_n: shift/rotate/load register with single-step and multi-cycle shift ops
module universal_shift_register_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input logic clock,
  input logic reset,
  universal_shift_register_n_if.slave bus
);
  localparam logic [2:0] M_SHR = 3'b000;
  localparam logic [2:0] M_SHL = 3'b001;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROR = 3'b100;
  localparam logic [2:0] M_ROL = 3'b101;
  localparam logic [2:0] M_ASR = 3'b110;
  logic [WIDTH-1:0] q, nq;
  logic so, nso;
  logic busy, done;
  logic [CNT_W-1:0] count;
  logic [2:0] lmode, op;
  logic shiftable;
  assign op = busy ? lmode : bus.mode;
  assign shiftable = bus.mode inside {M_SHR, M_SHL, M_ROR, M_ROL, M_ASR};
  always_comb begin
    nq = q;
    nso = so;
    case (op)
      M_SHR: begin nq = {bus.serial_in_l, q[WIDTH-1:1]}; nso = q[0]; end
      M_SHL: begin nq = {q[WIDTH-2:0], bus.serial_in_r}; nso = q[WIDTH-1]; end
      M_LOAD: nq = bus.data_load;
      M_ROR: begin nq = {q[0], q[WIDTH-1:1]}; nso = q[0]; end
      M_ROL: begin nq = {q[WIDTH-2:0], q[WIDTH-1]}; nso = q[WIDTH-1]; end
      M_ASR: begin nq = {q[WIDTH-1], q[WIDTH-1:1]}; nso = q[0]; end
      default: ;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
      so <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      count <= '0;
      lmode <= M_SHR;
    end else begin
      done <= 1'b0;
      if (bus.enable) begin
        if (busy) begin
          q <= nq;
          so <= nso;
          count <= count - 1'b1;
          if (count == CNT_W'(1)) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end else if (bus.start && shiftable) begin
          // a zero-length request completes immediately without going busy
          if (bus.shamt == '0) done <= 1'b1;
          else begin
            busy <= 1'b1;
            count <= bus.shamt;
            lmode <= bus.mode;
          end
        end else begin
          q <= nq;
          so <= nso;
        end
      end
    end
  end
  assign bus.out_final = q;
  assign bus.shift_out = so;
  assign bus.busy = busy;
  assign bus.done = done;
endmodule

// File: doc/universal_shift_register_n.md
UNIVERSAL_SHIFT_REGISTER_N -- requirements
Module: universal_shift_register_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width (>=2).
REQ-002 SHALL have parameter CNT_W, default 3, width of shift-amount input; 2**CNT_W >= WIDTH.
REQ-003 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  step enable; 0 freezes all state except reset.
REQ-006 SHALL have port mode  input  3  operation select (REQ-012).
REQ-007 SHALL have port start  input  1  request multi-cycle shift of shamt steps.
REQ-008 SHALL have port shamt  input  CNT_W  step count for multi-cycle shift.
REQ-009 SHALL have port data_load  input  WIDTH  parallel load value.
REQ-010 SHALL have port serial_in_l / serial_in_r  input  1 each  bit entering MSB on right shift / bit entering LSB on left shift.
REQ-011 SHALL have ports out_final  output  WIDTH  register contents; shift_out  output  1  last bit shifted out (registered); busy  output  1  multi-cycle op active; done  output  1  one-cycle completion pulse.

Function
REQ-012 Mode codes: 000 logical right (serial_in_l->MSB); 001 logical left (serial_in_r->LSB); 010 hold; 011 parallel load; 100 rotate right; 101 rotate left; 110 arithmetic right (MSB replicated); 111 hold (reserved).
REQ-013 Idle (busy=0), enable=1, start=0: one step of mode SHALL be applied per clock edge.
REQ-014 shift_out SHALL update on each shift/rotate step: right-type -> old LSB; left-type -> old MSB; unchanged on hold/load.
REQ-015 Idle, enable=1, start=1, mode in {000,001,100,101,110}, shamt>0: edge E0 latches mode and count=shamt, sets busy=1, register unchanged.
REQ-016 Busy: each edge with enable=1 SHALL apply one step of latched mode and decrement count; the edge where count reaches 0 sets busy=0 and done=1.
REQ-017 Result of N-step op SHALL be visible on out_final together with done=1, N+1 enabled edges after start sampled.
REQ-018 done SHALL be high exactly one cycle; cleared next edge regardless of enable.
REQ-019 start with shamt=0 (shiftable mode): register unchanged, busy stays 0, done=1 next cycle.
REQ-020 start with mode in {010,011,111}: treated as single step per REQ-013; busy and done not asserted.
REQ-021 While busy: mode, shamt, data_load, start SHALL be ignored; serial_in_l/serial_in_r sampled live each step.
REQ-022 enable=0 while busy: register, count, busy held; operation resumes when enable returns.
REQ-023 No combinational path from inputs to outputs; all outputs registered.

Reset
REQ-024 reset=1 at an edge SHALL set out_final=0, shift_out=0, busy=0, done=0, count=0, overriding enable and any operation in progress.
REQ-025 Reset mid-operation SHALL abandon the operation; no done pulse produced.

Verification (WIDTH=8, CNT_W=3)
REQ-026 Reset asserted one edge -> out_final=00000000, busy=0, done=0, shift_out=0.
REQ-027 mode=011, data_load=10101100 -> 10101100; mode=010 -> unchanged; mode=001, serial_in_r=0 -> 01011000, shift_out=1; mode=000, serial_in_l=0 -> 00101100, shift_out=0.
REQ-028 From 10101100, mode=110 one step -> 11010110, shift_out=0; mode=100 one step from 10101100 -> 01010110.
REQ-029 From 10101100, start=1, mode=101, shamt=3 -> busy=1 for 3 cycles, after 4th edge out_final=01100101, done=1 one cycle, busy=0.
REQ-030 Same op with enable=0 for 2 cycles mid-op and start pulsed while busy -> completion delayed exactly 2 cycles, result 01100101, start ignored.
REQ-031 start with shamt=0 -> done=1 next cycle, out_final unchanged; reset during busy -> all zero, no done.
